// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
package count_seq_pkg;

  // Controller states; the encoding is fixed so status decode stays stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Count direction as captured at start.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_seq_prescaler.sv
// Tick generator for the count sequencer: a free-running divider that
// pulses once every prescale_i+1 enabled cycles. Only instantiated when
// COUNT_SEQ_PRESCALE_EN is defined.
module count_seq_prescaler #(
  parameter int PS_WIDTH = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                clear_i,
  input  logic                en_i,
  input  logic [PS_WIDTH-1:0] prescale_i,
  output logic                tick_o
);

  logic [PS_WIDTH-1:0] cnt_q, cnt_d;

  // prescale_i is live; >= rather than == means lowering it below the
  // current count ticks immediately instead of wrapping the whole range.
  assign tick_o = (cnt_q >= prescale_i);

  // Next divider count: cleared on request, frozen when not enabled.
  always_comb begin
    // NOTE: every _d gets its default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PS_WIDTH'(1);
    end
  end

  // Divider register with synchronous clear.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencer: captures limit/direction/reload at start, steps the
// count once per tick, strobes tc at the terminal value and either stops
// in DONE (one-shot) or reloads (periodic). Start/pause/abort control with
// busy/done status. Defining COUNT_SEQ_PRESCALE_EN adds the prescale port
// and a divider that slows the tick; otherwise the count steps every cycle.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 4
`ifdef COUNT_SEQ_PRESCALE_EN
  ,
  parameter int PS_WIDTH = 4
`endif
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                pause,
  input  logic                abort,
  input  logic                dir,
  input  logic                reload,
  input  logic [WIDTH-1:0]    limit,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PS_WIDTH-1:0] prescale,
`endif
  output logic [WIDTH-1:0]    q,
  output logic                tc,
  output logic                busy,
  output logic                done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             reload_q, reload_d;

  logic             tick;
  logic             start_ok;
  logic             run_step;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] init_run;
  logic             at_term;

  // Terminal and reload values come only from the captured shadow copies,
  // so limit/dir/reload wiggling mid-run has no effect.
  assign term     = (dir_q == DIR_UP)   ? limit_q : '0;
  assign init_run = (dir_q == DIR_DOWN) ? limit_q : '0;
  assign at_term  = (count_q == term);

  // A start is only honoured from IDLE or DONE, and abort outranks it.
  assign start_ok = start && !abort && (state_q == IDLE || state_q == DONE);

  // An edge on which the count actually advances (or hits terminal).
  assign run_step = (state_q == RUN) && !abort && !pause && tick;

`ifdef COUNT_SEQ_PRESCALE_EN
  count_seq_prescaler #(
    .PS_WIDTH (PS_WIDTH)
  ) u_prescaler (
    .clk        (clk),
    .clr        (clr),
    .clear_i    (abort || start_ok),
    .en_i       ((state_q == RUN) && !pause && !abort),
    .prescale_i (prescale),
    .tick_o     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Next-state, next-count and shadow capture for the sequencer.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    dir_d    = dir_q;
    reload_d = reload_q;

    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          limit_d  = limit;
          dir_d    = dir;
          reload_d = reload;
          count_d  = (dir == DIR_DOWN) ? limit : '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (at_term) begin
            if (reload_q) begin
              count_d = init_run;
            end else begin
              state_d = DONE;
            end
          end else if (dir_q == DIR_UP) begin
            count_d = count_q + WIDTH'(1);
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, count and shadow registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      limit_q  <= '0;
      dir_q    <= DIR_UP;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      dir_q    <= dir_d;
      reload_q <= reload_d;
    end
  end

  assign q    = count_q;
  assign tc   = run_step && at_term;
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
`timescale 1ns/1ps
module tb_count_seq_ctrl;

  localparam int W   = 4;
  localparam int PSW = 4;

  logic         clk = 1'b0;
  logic         clr, start, pause, abort, dir, reload;
  logic [W-1:0] limit;
  logic [PSW-1:0] prescale;
  logic [W-1:0] q;
  logic         tc, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seq_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .pause    (pause),
    .abort    (abort),
    .dir      (dir),
    .reload   (reload),
    .limit    (limit),
`ifdef COUNT_SEQ_PRESCALE_EN
    .prescale (prescale),
`endif
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  // ---------------------------------------------------------------------
  // Reference model: a run is described by how many steps (pos) have been
  // taken toward the limit; the visible count is derived from that.
  // ---------------------------------------------------------------------
  bit m_run, m_paused, m_fin, m_down, m_rel;
  int m_lim, m_pos, m_ps;

  function automatic bit m_tick();
`ifdef COUNT_SEQ_PRESCALE_EN
    return m_ps >= int'(prescale);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int m_q();
    if (!m_run && !m_fin) return 0;
    return m_down ? (m_lim - m_pos) : m_pos;
  endfunction

  function automatic bit m_tc();
    return m_run && !m_paused && m_tick() && !pause && !abort && (m_pos == m_lim);
  endfunction

  task automatic model_edge();
    bit tk;
    tk = m_tick();
    if (clr) begin
      m_run = 0; m_paused = 0; m_fin = 0; m_down = 0; m_rel = 0;
      m_lim = 0; m_pos = 0; m_ps = 0;
    end else if (abort) begin
      m_run = 0; m_paused = 0; m_fin = 0; m_pos = 0; m_ps = 0;
    end else if (!m_run && start) begin
      m_run = 1; m_paused = 0; m_fin = 0;
      m_down = dir; m_rel = reload; m_lim = int'(limit);
      m_pos = 0; m_ps = 0;
    end else if (m_run && m_paused) begin
      if (!pause) m_paused = 0;
    end else if (m_run) begin
      if (pause) begin
        m_paused = 1;
      end else if (tk) begin
        m_ps = 0;
        if (m_pos == m_lim) begin
          if (m_rel) m_pos = 0;
          else begin m_run = 0; m_fin = 1; end
        end else begin
          m_pos++;
        end
      end else begin
        m_ps++;
      end
    end
  endtask

  // One rising edge for DUT and model, then step off the edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Directed stimulus rows: inputs to apply and outputs expected before the edge.
  typedef struct packed {
    logic st, ps, ab, dr, rl;
    logic [W-1:0] lim;
    logic [W-1:0] q;
    logic tc, busy, done;
  } row_t;

  function automatic row_t mk(input int st, ps, ab, dr, rl, lim, eq, etc, eb, ed);
    row_t r;
    r.st = 1'(st); r.ps = 1'(ps); r.ab = 1'(ab); r.dr = 1'(dr); r.rl = 1'(rl);
    r.lim = W'(lim); r.q = W'(eq); r.tc = 1'(etc); r.busy = 1'(eb); r.done = 1'(ed);
    return r;
  endfunction

  task automatic apply_row(input row_t r);
    start = r.st; pause = r.ps; abort = r.ab; dir = r.dr; reload = r.rl; limit = r.lim;
    @(negedge clk);
  endtask

  task automatic go_idle();
    start = 0; pause = 0; abort = 1;
    cycle();
    abort = 0;
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({q, tc, busy, done} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: q=%0d tc=%b busy=%b done=%b, required all zero", q, tc, busy, done);
    end
    cycle();
    clr = 0; start = 1; limit = 5; dir = 0; reload = 0;
    cycle();
    start = 0;
    cycle();
    cycle();
    @(negedge clk);
    checks++;
    if ({q, busy, done} !== {W'(2), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_prerun: q=%0d busy=%b done=%b, required q=2 busy=1 done=0", q, busy, done);
    end
    clr = 1;
    cycle();
    clr = 0;
    @(negedge clk);
    checks++;
    if ({q, tc, busy, done} !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_midrun: q=%0d tc=%b busy=%b done=%b, required all zero", q, tc, busy, done);
    end
    cycle();
  endtask

  task automatic test_one_shot_up();
    row_t seq [7] = '{
      mk(1,0,0,0,0,3, 0,0,0,0),
      mk(0,0,0,0,0,3, 0,0,1,0),
      mk(0,0,0,0,0,3, 1,0,1,0),
      mk(0,0,0,0,0,3, 2,0,1,0),
      mk(0,0,0,0,0,3, 3,1,1,0),
      mk(0,0,0,0,0,3, 3,0,0,1),
      mk(0,0,0,0,0,3, 3,0,0,1)};
    for (int i = 0; i < 7; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL one_shot_up row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

  // Includes a start pulse mid-run, which must be ignored.
  task automatic test_periodic_down();
    row_t seq [8] = '{
      mk(1,0,0,1,1,2, 0,0,0,0),
      mk(0,0,0,1,1,2, 2,0,1,0),
      mk(1,0,0,1,1,2, 1,0,1,0),
      mk(0,0,0,1,1,2, 0,1,1,0),
      mk(0,0,0,1,1,2, 2,0,1,0),
      mk(0,0,0,1,1,2, 1,0,1,0),
      mk(0,0,0,1,1,2, 0,1,1,0),
      mk(0,0,0,1,1,2, 2,0,1,0)};
    for (int i = 0; i < 8; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL periodic_down row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

  task automatic test_pause_abort();
    row_t seq [12] = '{
      mk(1,0,0,0,0,5, 0,0,0,0),
      mk(0,0,0,0,0,5, 0,0,1,0),
      mk(0,1,0,0,0,5, 1,0,1,0),
      mk(0,1,0,0,0,5, 1,0,1,0),
      mk(0,1,0,0,0,5, 1,0,1,0),
      mk(0,0,0,0,0,5, 1,0,1,0),
      mk(0,0,0,0,0,5, 1,0,1,0),
      mk(0,0,0,0,0,5, 2,0,1,0),
      mk(0,0,0,0,0,5, 3,0,1,0),
      mk(0,0,1,0,0,5, 4,0,1,0),
      mk(0,0,0,0,0,5, 0,0,0,0),
      mk(0,0,0,0,0,5, 0,0,0,0)};
    for (int i = 0; i < 12; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL pause_abort row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

  // limit=0 one-shot, restart from DONE with limit=1, abort+start together.
  task automatic test_limit_zero_restart();
    row_t seq [11] = '{
      mk(1,0,0,0,0,0, 0,0,0,0),
      mk(0,0,0,0,0,0, 0,1,1,0),
      mk(0,0,0,0,0,1, 0,0,0,1),
      mk(1,0,0,0,0,1, 0,0,0,1),
      mk(0,0,0,0,0,1, 0,0,1,0),
      mk(0,0,0,0,0,1, 1,1,1,0),
      mk(0,0,0,0,0,1, 1,0,0,1),
      mk(1,0,1,0,0,1, 1,0,0,1),
      mk(1,0,1,0,0,1, 0,0,0,0),
      mk(0,0,0,0,0,1, 0,0,0,0),
      mk(0,0,0,0,0,1, 0,0,0,0)};
    for (int i = 0; i < 11; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL limit_zero_restart row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

  // Mid-run input changes are ignored; abort on the terminal cycle kills tc.
  task automatic test_mid_run_inputs();
    row_t seq [11] = '{
      mk(1,0,0,0,0,2, 0,0,0,0),
      mk(0,0,0,1,1,7, 0,0,1,0),
      mk(0,0,0,1,1,7, 1,0,1,0),
      mk(0,0,0,1,1,7, 2,1,1,0),
      mk(0,0,0,1,1,7, 2,0,0,1),
      mk(1,0,0,0,0,2, 2,0,0,1),
      mk(0,0,0,0,0,2, 0,0,1,0),
      mk(0,0,0,0,0,2, 1,0,1,0),
      mk(0,0,1,0,0,2, 2,0,1,0),
      mk(0,0,0,0,0,2, 0,0,0,0),
      mk(0,0,0,0,0,2, 0,0,0,0)};
    for (int i = 0; i < 11; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL mid_run_inputs row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

  task automatic test_periodic_zero();
    row_t seq [6] = '{
      mk(1,0,0,0,1,0, 0,0,0,0),
      mk(0,0,0,0,1,0, 0,1,1,0),
      mk(0,0,0,0,1,0, 0,1,1,0),
      mk(0,0,0,0,1,0, 0,1,1,0),
      mk(0,0,1,0,1,0, 0,0,1,0),
      mk(0,0,0,0,1,0, 0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL periodic_zero row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
  endtask

`ifdef COUNT_SEQ_PRESCALE_EN
  task automatic test_prescale();
    row_t seq [8] = '{
      mk(1,0,0,0,0,1, 0,0,0,0),
      mk(0,0,0,0,0,1, 0,0,1,0),
      mk(0,0,0,0,0,1, 0,0,1,0),
      mk(0,0,0,0,0,1, 0,0,1,0),
      mk(0,0,0,0,0,1, 1,0,1,0),
      mk(0,0,0,0,0,1, 1,0,1,0),
      mk(0,0,0,0,0,1, 1,1,1,0),
      mk(0,0,0,0,0,1, 1,0,0,1)};
    prescale = 2;
    for (int i = 0; i < 8; i++) begin
      apply_row(seq[i]);
      checks++;
      if ({q, tc, busy, done} !== {seq[i].q, seq[i].tc, seq[i].busy, seq[i].done}) begin
        errors++;
        $display("FAIL prescale row %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, seq[i].q, seq[i].tc, seq[i].busy, seq[i].done);
      end
      cycle();
    end
    prescale = 0;
  endtask
`endif

  // Random control traffic against the reference model, every cycle.
  task automatic test_random();
    logic [W-1:0] eq;
    logic         etc, eb, ed;
    for (int i = 0; i < 1500; i++) begin
      clr    = ($urandom_range(0, 149) == 0);
      start  = ($urandom_range(0, 5) == 0);
      pause  = ($urandom_range(0, 7) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      dir    = 1'($urandom_range(0, 1));
      reload = 1'($urandom_range(0, 1));
      limit  = W'($urandom_range(0, 7));
`ifdef COUNT_SEQ_PRESCALE_EN
      if ($urandom_range(0, 7) == 0) prescale = PSW'($urandom_range(0, 3));
`endif
      @(negedge clk);
      eq  = W'(m_q());
      etc = m_tc();
      eb  = m_run;
      ed  = m_fin;
      checks++;
      if ({q, tc, busy, done} !== {eq, etc, eb, ed}) begin
        errors++;
        $display("FAIL random cycle %0d: q=%0d tc=%b busy=%b done=%b, required q=%0d tc=%b busy=%b done=%b",
                 i, q, tc, busy, done, eq, etc, eb, ed);
      end
      cycle();
    end
    clr = 0; start = 0; pause = 0; abort = 0;
    prescale = 0;
  endtask

  initial begin
    clr = 1; start = 0; pause = 0; abort = 0;
    dir = 0; reload = 0; limit = '0; prescale = '0;
    cycle();
    cycle();
    test_reset();
    test_one_shot_up();
    go_idle();
    test_periodic_down();
    go_idle();
    test_pause_abort();
    test_limit_zero_restart();
    test_mid_run_inputs();
    test_periodic_zero();
`ifdef COUNT_SEQ_PRESCALE_EN
    test_prescale();
    go_idle();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
